// File: rtl/matrix_add_scheduler.sv
// Round-robin scheduler sharing one 4x4 matrix-add engine between two
// requesters. Grants in IDLE, pulses eng_start, waits for eng_done with a
// timeout, then returns a single-cycle response to the granted requester.
module matrix_add_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  output logic        eng_start,
  output logic        eng_sel,
  input  logic        eng_done,
  output logic [1:0]  rsp_valid,
  output logic        rsp_err,
  output logic        busy,
  output logic        stray_err,
  output logic [15:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The wait counter holds the number of cycles since eng_start was raised,
  // so the abort lands exactly TIMEOUT cycles after the start pulse.
  localparam logic [7:0] WLIM = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] wcnt;
  logic [7:0] wcnt_nx;
  logic       sel_nx;
  logic       err_nx;
  logic       last_grant;

  // Next-state, grant and timeout decisions.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    sel_nx   = eng_sel;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx = START;
          wcnt_nx  = 8'd0;
          // Contention goes to whoever did not win last; otherwise the lone requester.
          sel_nx   = (req == 2'b11) ? ~last_grant : req[1];
        end
      end
      START: begin
        state_nx = WAIT;
        wcnt_nx  = wcnt + 8'd1;
      end
      WAIT: begin
        wcnt_nx = wcnt + 8'd1;
        // Completion is checked first so a done on the final cycle is not an error.
        if (eng_done) begin
          state_nx = RESP;
        end else if (wcnt == WLIM) begin
          state_nx = RESP;
          err_nx   = 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= 8'd0;
      eng_sel   <= 1'b0;
      eng_start <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      eng_sel   <= sel_nx;
      eng_start <= (state_nx == START);
      busy      <= (state_nx != IDLE);
      rsp_valid <= (state_nx == RESP) ? (eng_sel ? 2'b10 : 2'b01) : 2'b00;
      rsp_err   <= (state_nx == RESP) && err_nx;
    end
  end

  // Bookkeeping done while the response is on the wire: fairness and success count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_cnt     <= 16'd0;
    end else if (state == RESP) begin
      last_grant <= eng_sel;
      if (!rsp_err) begin
        op_cnt <= op_cnt + 16'd1;
      end
    end
  end

  // Sticky flag for engine completions that arrive when nothing is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stray_err <= 1'b0;
    end else if (eng_done && (state != WAIT)) begin
      stray_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_add_scheduler.sv
// Directed bench for matrix_add_scheduler with a timestamp-based reference model.
module tb_matrix_add_scheduler;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic        eng_start;
  logic        eng_sel;
  logic        eng_done;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic        busy;
  logic        stray_err;
  logic [15:0] op_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: an operation is described by the cycle its start pulse
  // appears (m_s) and the cycle its response appears (m_r, -1 until known).
  int          cyc;
  bit          m_active;
  bit          m_sel;
  bit          m_last;
  bit          m_err;
  bit          m_stray;
  logic [15:0] m_cnt;
  int          m_s;
  int          m_r;

  always #5 clk = ~clk;

  matrix_add_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .eng_start (eng_start),
    .eng_sel   (eng_sel),
    .eng_done  (eng_done),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .stray_err (stray_err),
    .op_cnt    (op_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_sel    = 1'b0;
    m_last   = 1'b1;
    m_err    = 1'b0;
    m_stray  = 1'b0;
    m_cnt    = 16'd0;
    m_s      = -10;
    m_r      = -1;
  endtask

  // Applies the rules to the inputs seen at the end of cycle cyc.
  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else if (!m_active) begin
      if (eng_done) m_stray = 1'b1;
      if (req != 2'b00) begin
        if (req == 2'b01)      m_sel = 1'b0;
        else if (req == 2'b10) m_sel = 1'b1;
        else                   m_sel = ~m_last;
        m_active = 1'b1;
        m_s      = cyc + 1;
        m_r      = -1;
      end
    end else if (cyc == m_s) begin
      if (eng_done) m_stray = 1'b1;
    end else if (m_r < 0) begin
      if (eng_done) begin
        m_r   = cyc + 1;
        m_err = 1'b0;
      end else if (cyc - m_s == TIMEOUT - 1) begin
        m_r   = cyc + 1;
        m_err = 1'b1;
      end
    end else begin
      if (eng_done) m_stray = 1'b1;
      if (!m_err) m_cnt = m_cnt + 16'd1;
      m_last   = m_sel;
      m_active = 1'b0;
    end
    cyc++;
  endtask

  task automatic compare();
    bit         st;
    bit         rs;
    logic [1:0] rv;
    st = m_active && (cyc == m_s);
    rs = m_active && (m_r >= 0) && (cyc == m_r);
    rv = rs ? (m_sel ? 2'b10 : 2'b01) : 2'b00;
    chk("eng_start", eng_start, st);
    chk("busy", busy, m_active);
    chk("eng_sel", eng_sel, m_sel);
    chk("rsp_valid", rsp_valid, rv);
    if (rs) chk("rsp_err", rsp_err, m_err);
    chk("stray_err", stray_err, m_stray);
    chk("op_cnt", op_cnt, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    if (rst_n) compare();
  endtask

  task automatic wait_start(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (eng_start) got = 1'b1;
    end
    chk("start_seen", got, 1'b1);
  endtask

  // One operation: done pulse k cycles after eng_start, or k=0 for no done.
  task automatic do_op(input logic [1:0] r, input int k, input bit hold,
                       output logic sel_o, output logic err_o);
    bit got;
    req = req | r;
    wait_start(got);
    sel_o = eng_sel;
    if (k > 0) begin
      repeat (k) step();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
    end else begin
      repeat (TIMEOUT) step();
    end
    err_o = rsp_err;
    chk("rsp_onehot", rsp_valid, sel_o ? 2'b10 : 2'b01);
    step();
    if (!hold) req[sel_o] = 1'b0;
  endtask

  initial begin
    logic sel;
    logic err;
    bit   got;
    cyc      = 0;
    rst_n    = 1'b0;
    req      = 2'b00;
    eng_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", eng_start, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_op_cnt", op_cnt, 16'd0);
    rst_n = 1'b1;
    step();

    // Contention held across four operations alternates starting with 0.
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      do_op(2'b11, 2 + i, 1'b1, sel, err);
      chk("contention_grant", sel, i % 2);
      chk("contention_err", err, 1'b0);
    end
    req = 2'b00;
    chk("op_cnt_after_contention", op_cnt, 16'd4);
    step();

    // Single request, done three cycles after start.
    do_op(2'b01, 3, 1'b0, sel, err);
    chk("single_sel", sel, 1'b0);
    chk("single_err", err, 1'b0);
    chk("single_op_cnt", op_cnt, 16'd5);
    step();

    // Timeout from requester 1.
    do_op(2'b10, 0, 1'b0, sel, err);
    chk("timeout_sel", sel, 1'b1);
    chk("timeout_err", err, 1'b1);
    chk("timeout_op_cnt", op_cnt, 16'd5);
    step();

    // Done on the final WAIT cycle still counts as completion.
    do_op(2'b01, TIMEOUT - 1, 1'b0, sel, err);
    chk("boundary_err", err, 1'b0);
    chk("boundary_op_cnt", op_cnt, 16'd6);
    chk("stray_before", stray_err, 1'b0);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    step();
    chk("stray_set", stray_err, 1'b1);
    repeat (3) step();
    chk("stray_sticky", stray_err, 1'b1);

    // Reset while waiting on requester 1.
    req = 2'b10;
    wait_start(got);
    step();
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("wrst_busy", busy, 1'b0);
    chk("wrst_start", eng_start, 1'b0);
    chk("wrst_sel", eng_sel, 1'b0);
    chk("wrst_rsp_valid", rsp_valid, 2'b00);
    chk("wrst_rsp_err", rsp_err, 1'b0);
    chk("wrst_stray", stray_err, 1'b0);
    chk("wrst_op_cnt", op_cnt, 16'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    req   = 2'b11;
    do_op(2'b11, 2, 1'b0, sel, err);
    chk("post_reset_grant", sel, 1'b0);
    do_op(2'b10, 2, 1'b0, sel, err);
    chk("post_reset_second", sel, 1'b1);
    chk("post_reset_op_cnt", op_cnt, 16'd2);
    step();

    // Success counter wraps.
    force dut.op_cnt = 16'hFFFF;
    #1;
    release dut.op_cnt;
    m_cnt = 16'hFFFF;
    do_op(2'b01, 4, 1'b0, sel, err);
    chk("wrap_op_cnt", op_cnt, 16'h0000);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_add_scheduler.md
MATRIX_ADD_SCHEDULER -- requirements
Module: matrix_add_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum number of WAIT cycles allowed before an operation is aborted; legal range 2..255.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  2  level request per requester i; held high until rsp_valid[i], dropped the following cycle.
REQ-005 eng_start  output  1  single-cycle start pulse to the shared 4x4 add engine.
REQ-006 eng_sel  output  1  index of granted requester; drives the engine operand/result mux.
REQ-007 eng_done  input  1  single-cycle completion pulse from the engine.
REQ-008 rsp_valid  output  2  one-hot, single-cycle completion pulse to the granted requester.
REQ-009 rsp_err  output  1  qualifies rsp_valid; 1 = timed out, 0 = completed.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 stray_err  output  1  sticky flag; eng_done was seen outside WAIT.
REQ-012 op_cnt  output  16  count of rsp_valid pulses with rsp_err=0; wraps 0xFFFF->0x0000.

Function
REQ-013 FSM states: IDLE, START, WAIT, RESP; all outputs are registered.
REQ-014 IDLE: if any req bit is high, latch the winner into eng_sel and go to START; otherwise stay in IDLE.
REQ-015 Arbitration: if only one bit is high, grant that requester; if both are high, grant the requester != last_grant (round-robin).
REQ-016 START: eng_start=1 for exactly this cycle; clear wait counter; go to WAIT.
REQ-017 WAIT: the wait counter increments each cycle; eng_done=1 -> RESP with err=0; else counter==TIMEOUT-1 -> RESP with err=1.
REQ-018 eng_done in the same cycle the counter reaches its limit: completion wins, err=0.
REQ-019 RESP: rsp_valid[eng_sel]=1 and rsp_err=err for one cycle; last_grant<=eng_sel; op_cnt increments if err=0; go to IDLE.
REQ-020 eng_sel is stable from the cycle START is entered until RESP exits; it is only updated in IDLE.
REQ-021 Latency: req sampled in IDLE at cycle N -> eng_start at N+1; eng_done at N+k (k>=2) -> rsp_valid at N+k+1.
REQ-022 Minimum turnaround: IDLE is occupied for at least 1 cycle between consecutive operations.
REQ-023 eng_done in IDLE, START or RESP is ignored for FSM purposes and sets stray_err=1; only reset clears stray_err.
REQ-024 A req bit that is high in IDLE is treated as a new request, including a requester that failed to drop req after its rsp_valid.
REQ-025 Changes to req while busy=1 have no effect on the operation in flight.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, eng_start=0, eng_sel=0, rsp_valid=0, rsp_err=0, busy=0, stray_err=0, op_cnt=0, wait counter=0, last_grant=1 (requester 0 wins the first contention).
REQ-027 Reset asserted mid-operation (START, WAIT or RESP) aborts the operation with no rsp_valid pulse; operation resumes from IDLE after rst_n deasserts.

Verification
REQ-028 Single request: req=01, eng_done 3 cycles after eng_start -> eng_sel=0, rsp_valid=01, rsp_err=0, op_cnt=1.
REQ-029 Contention: req=11 held across four operations -> grants alternate 0,1,0,1; eng_start never overlaps busy operations.
REQ-030 Timeout: req=10, eng_done never asserted -> rsp_valid=10, rsp_err=1 exactly TIMEOUT cycles after eng_start; op_cnt unchanged.
REQ-031 Boundary: eng_done coincides with the final WAIT cycle -> rsp_err=0; an additional eng_done pulse in IDLE -> stray_err=1 and stays 1.
REQ-032 Reset in WAIT: rst_n low for 1 cycle -> all outputs 0 immediately; no rsp_valid; the next req=11 grants requester 0.
REQ-033 Wrap: preload op_cnt to 0xFFFF via force, complete one operation -> op_cnt=0x0000.
